// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-tick generator for the UART datapath. A programmable prescaler divides
// clk into an oversample tick (os_tick) for the receiver. A phase counter,
// advanced by os_tick, produces a bit-period tick (bit_tick) for the
// transmitter and a mid-bit tick (mid_tick) for receiver sampling.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        reset-default baud rate
//   OVERSAMPLE  oversample ticks per bit (even, >= 4)
//   DIV_W       width of the divisor register and prescaler counter
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable; low holds counters at zero
//   sync       in   single-cycle phase restart (RX start-bit detect)
//   div_load   in   load div_value into the divisor register
//   div_value  in   new divisor, clk cycles per oversample tick (0 -> 1)
//   div_q      out  current divisor register
//   os_tick    out  one-cycle pulse per oversample period
//   mid_tick   out  one-cycle pulse at the bit midpoint
//   bit_tick   out  one-cycle pulse per bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic [DIV_W-1:0] div_q,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick
);

  localparam longint DEFAULT_DIV = longint'(CLK_FREQ) / (longint'(BAUD) * longint'(OVERSAMPLE));
  localparam longint DIV_LIMIT   = longint'(1) << DIV_W;
  localparam int     PH_W        = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);

  if (DEFAULT_DIV < 1 || DEFAULT_DIV >= DIV_LIMIT) begin : g_bad_div
    $error("uart_baud_gen: DEFAULT_DIV out of range for DIV_W");
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("uart_baud_gen: OVERSAMPLE must be even and >= 4");
  end

  logic [DIV_W-1:0] cnt;
  logic [PH_W-1:0]  ph;
  logic             cnt_tc;
  logic             ph_last;
  logic             ph_mid;
  logic [DIV_W-1:0] div_next;

  // div_q is never zero, so div_q-1 cannot wrap.
  always_comb begin
    cnt_tc   = (cnt == (div_q - DIV_W'(1)));
    ph_last  = (ph == PH_LAST);
    ph_mid   = (ph == PH_MID);
    div_next = (div_value == '0) ? DIV_W'(1) : div_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_RST;
      cnt      <= '0;
      ph       <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (div_load) begin
      div_q    <= div_next;
      cnt      <= '0;
      ph       <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else if (sync || !en) begin
      cnt      <= '0;
      ph       <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (cnt_tc) begin
        cnt     <= '0;
        os_tick <= 1'b1;
        // Phase advances once per oversample period; mid and bit ticks
        // therefore always coincide with an os_tick.
        if (ph_last) begin
          ph       <= '0;
          bit_tick <= 1'b1;
        end else begin
          ph <= ph + PH_W'(1);
        end
        if (ph_mid) begin
          mid_tick <= 1'b1;
        end
      end else begin
        cnt     <= cnt + DIV_W'(1);
        os_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Directed bench for uart_baud_gen with CLK_FREQ=1600, BAUD=10, OVERSAMPLE=16,
// giving a reset divisor of 10. Expected tick patterns come from closed-form
// arithmetic on the edge index since the last restart.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int DIV_W = 16;
  localparam int OS    = 16;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sync;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic [DIV_W-1:0] div_q;
  logic             os_tick;
  logic             mid_tick;
  logic             bit_tick;

  int checks = 0;
  int errors = 0;

  uart_baud_gen #(
    .CLK_FREQ  (1600),
    .BAUD      (10),
    .OVERSAMPLE(OS),
    .DIV_W     (DIV_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .div_load (div_load),
    .div_value(div_value),
    .div_q    (div_q),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ticks();
    return {os_tick, mid_tick, bit_tick};
  endfunction

  // Run n enabled edges from a fresh phase origin (cnt=0, ph=0) and compare
  // {os,mid,bit} against the ideal pattern for divisor div.
  task automatic run_window(input string tag, input int div, input int n);
    logic [2:0] exp;
    for (int i = 1; i <= n; i++) begin
      step();
      exp[2] = (i % div) == 0;
      exp[1] = (i % (OS * div)) == (OS / 2) * div;
      exp[0] = (i % (OS * div)) == 0;
      check($sformatf("%s_e%0d", tag, i), 32'(ticks()), 32'(exp));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    div_load  = 1'b0;
    div_value = '0;

    // Reset state
    #12;
    check("rst_div_q", 32'(div_q), 32'd10);
    check("rst_ticks", 32'(ticks()), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("idle_ticks", 32'(ticks()), 32'd0);
    check("idle_div_q", 32'(div_q), 32'd10);

    // 1: default rate, first mid at 80, first bit at 160, then every 160
    en = 1'b1;
    run_window("t1", 10, 400);

    // 2: sync mid-count at cycle 47 of a fresh window
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t2_sync_edge", 32'(ticks()), 32'd0);
    run_window("t2_pre", 10, 47);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t2_sync47", 32'(ticks()), 32'd0);
    run_window("t2_post", 10, 200);

    // 3: runtime divisor load 3, then 0 (clamped to 1)
    run_window("t3_pre", 10, 35);
    div_value = 16'd3;
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
    check("t3_div3_q", 32'(div_q), 32'd3);
    check("t3_div3_ticks", 32'(ticks()), 32'd0);
    run_window("t3_div3", 3, 150);
    div_value = 16'd0;
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
    check("t3_div0_q", 32'(div_q), 32'd1);
    check("t3_div0_ticks", 32'(ticks()), 32'd0);
    run_window("t3_div1", 1, 64);

    // 4: enable dropped mid-bit for 25 cycles
    div_value = 16'd10;
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
    check("t4_div_q", 32'(div_q), 32'd10);
    run_window("t4_pre", 10, 85);
    en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      check($sformatf("t4_off_ticks%0d", i), 32'(ticks()), 32'd0);
      check($sformatf("t4_off_div%0d", i), 32'(div_q), 32'd10);
    end
    en = 1'b1;
    run_window("t4_post", 10, 200);

    // 5: async reset while os_tick is high, with a non-default divisor loaded
    div_value = 16'd3;
    div_load  = 1'b1;
    step();
    div_load  = 1'b0;
    run_window("t5_pre", 3, 9);
    check("t5_os_high", 32'(os_tick), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ticks", 32'(ticks()), 32'd0);
    check("t5_rst_div_q", 32'(div_q), 32'd10);
    step();
    check("t5_hold_ticks", 32'(ticks()), 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    step();

    // 6: div_load and sync together with en low
    div_value = 16'd5;
    div_load  = 1'b1;
    sync      = 1'b1;
    step();
    div_load  = 1'b0;
    sync      = 1'b0;
    check("t6_div_q", 32'(div_q), 32'd5);
    check("t6_ticks", 32'(ticks()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t6_idle%0d", i), 32'(ticks()), 32'd0);
    end
    en = 1'b1;
    run_window("t6_run", 5, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-tick generator for the UART datapath, replacing the fixed single-rate counter. A programmable clock prescaler produces an oversample tick (default 16x baud) for the receiver. A phase counter on top of it produces a bit tick for the transmitter and a mid-bit tick for receiver sampling. Supports runtime divisor load, enable gating and phase resync on an RX start-bit edge.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, reset-default baud rate
OVERSAMPLE, 16, oversample ticks per bit; even, >= 4
DIV_W, 16, width of prescaler divisor and counter
DEFAULT_DIV, CLK_FREQ/(BAUD*OVERSAMPLE), reset divisor (integer division); elaboration error if < 1 or >= 2**DIV_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; low = idle, counters held at 0
sync  in  1  single-cycle phase restart (RX start-bit detect)
div_load  in  1  load div_value into divisor register
div_value  in  DIV_W  new divisor (clk cycles per oversample tick)
div_q  out  DIV_W  current divisor register
os_tick  out  1  one-cycle pulse per oversample period
mid_tick  out  1  one-cycle pulse at bit midpoint
bit_tick  out  1  one-cycle pulse per bit period

Behaviour:
- Reset (async, rst_n low): div_q=DEFAULT_DIV, prescaler cnt=0, phase ph=0, os_tick=mid_tick=bit_tick=0. Release is synchronous to next clk edge.
- All outputs registered; each tick is high for exactly one clk cycle.
- Priority per edge, highest first: div_load, sync, en low, normal count.
- div_load: div_q <= (div_value==0 ? 1 : div_value); cnt<=0; ph<=0; all ticks <=0. Applies even when en=0.
- sync (no div_load): cnt<=0, ph<=0, all ticks <=0.
- en=0: cnt<=0, ph<=0, ticks<=0; div_q retained.
- Normal count (en=1):
  - If cnt==div_q-1: cnt<=0, os_tick<=1, ph advances. Otherwise cnt<=cnt+1, os_tick<=0.
  - Phase advance: if ph==OVERSAMPLE-1, ph<=0 and bit_tick<=1. Otherwise ph<=ph+1.
  - mid_tick<=1 on the advance where ph==OVERSAMPLE/2-1.
  - bit_tick and mid_tick are 0 on every edge where they are not set.
- Latency after en rises, sync or div_load (counting from the first enabled edge with cnt=0):
  - first os_tick visible after div_q edges;
  - first mid_tick after (OVERSAMPLE/2)*div_q edges;
  - first bit_tick after OVERSAMPLE*div_q edges.
- Steady-state periods: os_tick every div_q cycles; bit_tick every OVERSAMPLE*div_q cycles; mid_tick offset half a bit period from bit_tick.
- div_q==1: os_tick high continuously while en=1 (one pulse per cycle).
- bit_tick and os_tick coincide on the wrap edge; mid_tick and os_tick coincide at the midpoint; bit_tick and mid_tick never coincide.
- Counter widths: cnt is DIV_W bits; ph is clog2(OVERSAMPLE) bits. Neither exceeds its terminal value; no overflow paths.
- Reset asserted mid-count: immediate return to reset state, including any in-flight tick.

Test Plan:
1. Params CLK_FREQ=1600, BAUD=10, OVERSAMPLE=16 (DEFAULT_DIV=10); release reset, en=1 -> div_q=10; os_tick every 10 cycles; first mid_tick at edge 80, first bit_tick at edge 160, then bit_tick every 160 cycles.
2. Mid-count sync pulse at cycle 47 -> no ticks until 10 edges later; next mid_tick 80 edges and next bit_tick 160 edges after sync.
3. div_load with div_value=3 while running -> div_q=3, phase restarts; os_tick every 3 cycles, bit_tick every 48 cycles. Repeat with div_value=0 -> div_q=1, os_tick high every cycle, bit_tick every 16 cycles.
4. en low for 25 cycles mid-bit, then high -> all ticks 0 while low, div_q unchanged; timing restarts from zero on re-enable.
5. Assert rst_n low asynchronously (between clk edges) while os_tick is high -> os_tick, mid_tick and bit_tick drop immediately; div_q returns to 10.
6. Simultaneous div_load=1 and sync=1 with en=0 -> divisor loads, counters cleared, no tick emitted.
